alsu_req_sequencer: RTL and testbench
=====================================

Name: alsu_req_sequencer

Overview:
- Front-end controller that shares one ALSU instance between two requesters.
- Each requester presents a full command (operands, opcode, control bits) on a valid/ready interface.
- Round-robin arbitration grants one command at a time. The block drives the ALSU input pins for exactly one cycle, waits out the ALSU register latency, captures the ALSU result and returns it with the requester ID on a single backpressured response port.
- Rejects unsupported opcodes 6/7 locally so the ALSU never enters its invalid-op path.

Parameters:
- LATENCY, 2: clocks from the ALSU input-drive cycle to the cycle in which alsu_out holds the result (ALSU input register plus output register); legal 1..7.
- FULL_ADDER, "ON": mirrors the ALSU setting. "ON": cin from the command is forwarded. "OFF": alsu_cin is forced to 0.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_a, req0_b  in  3 each  operands
- req0_op  in  3  opcode
- req0_ctrl  in  7  {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_ctrl: same as requester 0
- alsu_A, alsu_B, alsu_opcode  out  3 each  to ALSU
- alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  to ALSU
- alsu_out  in  6  ALSU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued the command
- rsp_data  out  6  result; 0 when rsp_err=1
- rsp_err  out  1  command rejected (opcode 6 or 7)
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, rr_ptr=0, wait counter 0, captured command 0.
- Reset mid-operation: FSM returns to IDLE immediately and any pending command or response is dropped. The ALSU is not reset by this block.
- IDLE:
  - Grant goes to the valid requester. If both are valid, rr_ptr selects the winner (0 = req0, 1 = req1).
  - reqN_ready = (state==IDLE) && grantN, combinational; at most one ready is high.
  - On the handshake: latch {id, a, b, op, ctrl}; set rr_ptr = ~id.
  - If op is 6 or 7: go to RESP with rsp_err=1, rsp_data=0, and no ALSU activity. Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - Drive alsu_* from the latched command. If FULL_ADDER=="OFF", alsu_cin=0.
  - Load the wait counter with LATENCY, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, capture alsu_out into rsp_data, set rsp_err=0, and go to RESP.
- Idle drive: in every state except ISSUE, all alsu_* outputs are 0. This makes ALSU opcode 0 with no bypass/reduction, and keeps the ALSU invalid-op/led toggle path quiet.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No requester ready is asserted while in RESP, so there is one command in flight at most.
- Timing, LATENCY=2:
  - Accept at cycle 0, ISSUE at cycle 1, WAIT at cycles 2–3, capture at the end of cycle 3, rsp_valid from cycle 4.
  - Minimum command-to-command spacing is 5 cycles.
  - A rejected opcode gives rsp_valid at cycle 1.
- Shift/rotate ops (4/5):
  - Forwarded unchanged; the result depends on ALSU internal state.
  - The sequencer makes no guarantee beyond capturing alsu_out at the defined cycle.
- A requester may drop valid before it is granted; nothing is latched without a handshake.

Test Plan:
- Release reset; req0 sends a=3, b=4, op=2, cin=1 -> req0_ready high at cycle 0; alsu_opcode=2 only in cycle 1; rsp_valid at cycle 4 with rsp_id=0, rsp_data=8, rsp_err=0.
- Both requesters valid continuously after reset, rsp_ready=1 -> grant order req0, req1, req0, req1; rsp_id alternates; both readys are never high together.
- req1 sends a=7, b=7, op=3 -> rsp_data=49 (6'b110001), rsp_id=1. Repeat with FULL_ADDER="OFF", op=2, a=7, b=7, cin=1 -> rsp_data=14.
- req0 sends op=7 -> rsp_valid at cycle 1, rsp_err=1, rsp_data=0; alsu_opcode stays 0 throughout.
- Hold rsp_ready=0 for 5 cycles while req1 is valid -> rsp fields stable, req1_ready stays 0; the cycle after rsp_ready=1, req1 is granted.
- Assert rst low during WAIT -> all outputs 0 at once, no response after release; the next command completes normally with rr_ptr=0.

Source files
------------

// File: rtl/alsu_req_sequencer.sv
// rtl/alsu_req_sequencer.sv - round-robin front end sharing one ALSU between two requesters
module alsu_req_sequencer #(
  parameter int    LATENCY    = 2,
  parameter string FULL_ADDER = "ON"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic [6:0] req0_ctrl,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  input  logic [2:0] req1_op,
  input  logic [6:0] req1_ctrl,
  output logic [2:0] alsu_A,
  output logic [2:0] alsu_B,
  output logic [2:0] alsu_opcode,
  output logic       alsu_cin,
  output logic       alsu_serial_in,
  output logic       alsu_direction,
  output logic       alsu_red_op_A,
  output logic       alsu_red_op_B,
  output logic       alsu_bypass_A,
  output logic       alsu_bypass_B,
  input  logic [5:0] alsu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [5:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT    = 3'(LATENCY);
  localparam bit         CIN_EN = (FULL_ADDER != "OFF");

  state_t     state_q, state_d;
  logic       rr_ptr;
  logic [2:0] wait_cnt;
  logic       cmd_id;
  logic [2:0] cmd_a, cmd_b, cmd_op;
  logic [6:0] cmd_ctrl;
  logic [5:0] rsp_data_q;
  logic       rsp_err_q;

  logic       grant0, grant1, accept, issue;
  logic [2:0] sel_a, sel_b, sel_op;
  logic [6:0] sel_ctrl;
  logic       sel_bad;

  // Grants are suppressed while reset is held so every output reads 0 in reset.
  assign grant0 = rst && req0_valid && (!req1_valid || !rr_ptr);
  assign grant1 = rst && req1_valid && (!req0_valid ||  rr_ptr);

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_a    = grant1 ? req1_a    : req0_a;
  assign sel_b    = grant1 ? req1_b    : req0_b;
  assign sel_op   = grant1 ? req1_op   : req0_op;
  assign sel_ctrl = grant1 ? req1_ctrl : req0_ctrl;
  assign sel_bad  = (sel_op[2:1] == 2'b11);

  // ALSU pins carry the command only during ISSUE; zero elsewhere keeps the ALSU on a harmless AND.
  assign issue          = (state_q == ISSUE);
  assign alsu_A         = issue ? cmd_a  : 3'd0;
  assign alsu_B         = issue ? cmd_b  : 3'd0;
  assign alsu_opcode    = issue ? cmd_op : 3'd0;
  assign alsu_cin       = issue && CIN_EN && cmd_ctrl[6];
  assign alsu_serial_in = issue && cmd_ctrl[5];
  assign alsu_direction = issue && cmd_ctrl[4];
  assign alsu_red_op_A  = issue && cmd_ctrl[3];
  assign alsu_red_op_B  = issue && cmd_ctrl[2];
  assign alsu_bypass_A  = issue && cmd_ctrl[1];
  assign alsu_bypass_B  = issue && cmd_ctrl[0];

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = cmd_id;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: rejected opcodes skip straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = sel_bad ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_cnt == 3'd1) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, arbitration pointer, latency counter and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= 1'b0;
      wait_cnt   <= 3'd0;
      cmd_id     <= 1'b0;
      cmd_a      <= 3'd0;
      cmd_b      <= 3'd0;
      cmd_op     <= 3'd0;
      cmd_ctrl   <= 7'd0;
      rsp_data_q <= 6'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_id   <= grant1;
            cmd_a    <= sel_a;
            cmd_b    <= sel_b;
            cmd_op   <= sel_op;
            cmd_ctrl <= sel_ctrl;
            rr_ptr   <= ~grant1;
            if (sel_bad) begin
              rsp_data_q <= 6'd0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        ISSUE: wait_cnt <= LAT;
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            rsp_data_q <= alsu_out;
            rsp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_req_sequencer.sv
// tb/tb_alsu_req_sequencer.sv - directed self-checking bench for alsu_req_sequencer
module tb_alsu_req_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_a = 3'd0, req0_b = 3'd0, req0_op = 3'd0;
  logic [2:0] req1_a = 3'd0, req1_b = 3'd0, req1_op = 3'd0;
  logic [6:0] req0_ctrl = 7'd0, req1_ctrl = 7'd0;
  logic       rsp_ready = 1'b0;

  logic       req0_ready, req1_ready;
  logic [2:0] alsu_A, alsu_B, alsu_opcode;
  logic       alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B;
  logic       alsu_bypass_A, alsu_bypass_B;
  logic [5:0] alsu_out = 6'd0;
  logic       rsp_valid, rsp_id, rsp_err, busy;
  logic [5:0] rsp_data;

  logic       off_req0_ready, off_req1_ready;
  logic [2:0] off_alsu_A, off_alsu_B, off_alsu_opcode;
  logic       off_alsu_cin, off_alsu_serial_in, off_alsu_direction, off_alsu_red_op_A;
  logic       off_alsu_red_op_B, off_alsu_bypass_A, off_alsu_bypass_B;
  logic [5:0] off_alsu_out = 6'd0;
  logic       off_rsp_valid, off_rsp_id, off_rsp_err, off_busy;
  logic [5:0] off_rsp_data;

  int total = 0;
  int bad   = 0;

  alsu_req_sequencer #(.LATENCY(2), .FULL_ADDER("ON")) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_ctrl(req1_ctrl),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode), .alsu_cin(alsu_cin),
    .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  alsu_req_sequencer #(.LATENCY(2), .FULL_ADDER("OFF")) dut_off (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(off_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(off_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_ctrl(req1_ctrl),
    .alsu_A(off_alsu_A), .alsu_B(off_alsu_B), .alsu_opcode(off_alsu_opcode),
    .alsu_cin(off_alsu_cin), .alsu_serial_in(off_alsu_serial_in),
    .alsu_direction(off_alsu_direction), .alsu_red_op_A(off_alsu_red_op_A),
    .alsu_red_op_B(off_alsu_red_op_B), .alsu_bypass_A(off_alsu_bypass_A),
    .alsu_bypass_B(off_alsu_bypass_B), .alsu_out(off_alsu_out),
    .rsp_valid(off_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(off_rsp_id),
    .rsp_data(off_rsp_data), .rsp_err(off_rsp_err), .busy(off_busy)
  );

  // Reference ALSU: input register then output register, arithmetic/logic ops only.
  function automatic logic [5:0] alsu_f(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] op, input logic cin);
    case (op)
      3'd0:    return {3'd0, a & b};
      3'd1:    return {3'd0, a ^ b};
      3'd2:    return 6'(a) + 6'(b) + 6'(cin);
      3'd3:    return 6'(a) * 6'(b);
      default: return 6'd0;
    endcase
  endfunction

  logic [9:0] m_in = 10'd0, o_in = 10'd0;

  always @(posedge clk) begin
    m_in         <= {alsu_A, alsu_B, alsu_opcode, alsu_cin};
    alsu_out     <= alsu_f(m_in[9:7], m_in[6:4], m_in[3:1], m_in[0]);
    o_in         <= {off_alsu_A, off_alsu_B, off_alsu_opcode, off_alsu_cin};
    off_alsu_out <= alsu_f(o_in[9:7], o_in[6:4], o_in[3:1], o_in[0]);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command from requester id, checking pins per cycle and the response latency.
  task automatic send(input bit id, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] op, input logic [6:0] ctrl,
                      input int exp_data, input int exp_off, input bit exp_err);
    int n;
    rsp_ready = 1'b1;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_ctrl = ctrl;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_ctrl = ctrl;
    end
    @(negedge clk);
    check_eq("grant_ready", id ? req1_ready : req0_ready, 1);
    check_eq("other_ready", id ? req0_ready : req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      check_eq("alsu_opcode", alsu_opcode, (n == 1 && !exp_err) ? op : 3'd0);
      if (n == 1 && !exp_err) begin
        check_eq("alsu_A", alsu_A, a);
        check_eq("alsu_cin_on", alsu_cin, ctrl[6]);
        check_eq("alsu_cin_off", off_alsu_cin, 0);
      end
      if (rsp_valid) break;
      step();
    end
    check_eq("rsp_latency", n, exp_err ? 1 : 4);
    check_eq("rsp_id", rsp_id, id);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("rsp_data_off", off_rsp_data, exp_off);
    step();
  endtask

  task automatic wait_rsp();
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
      step();
    end
    check_eq("rsp_in_time", n < 30, 1);
  endtask

  initial begin
    int n, grants, resps;
    bit last_id, seen;

    // Reset state, with a requester already asking.
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_opcode", alsu_opcode, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    send(1'b0, 3'd3, 3'd4, 3'd2, 7'b1000000, 8, 7, 1'b0);
    send(1'b1, 3'd7, 3'd7, 3'd3, 7'b0000000, 49, 49, 1'b0);
    send(1'b1, 3'd7, 3'd7, 3'd2, 7'b1000000, 15, 14, 1'b0);
    send(1'b0, 3'd1, 3'd2, 3'd7, 7'b0000000, 0, 0, 1'b1);
    send(1'b1, 3'd5, 3'd1, 3'd6, 7'b0000000, 0, 0, 1'b1);

    // Backpressure: response held while req1 waits.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 3'd1; req0_b = 3'd2; req0_op = 3'd1; req0_ctrl = 7'd0;
    @(negedge clk);
    check_eq("bp_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 3'd5; req1_b = 3'd6; req1_op = 3'd0; req1_ctrl = 7'd0;
    wait_rsp();
    check_eq("bp_data", rsp_data, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check_eq("bp_hold_valid", rsp_valid, 1);
      check_eq("bp_hold_data", rsp_data, 3);
      check_eq("bp_hold_id", rsp_id, 0);
      check_eq("bp_ready1_low", req1_ready, 0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready1_resp", req1_ready, 0);
    step();
    @(negedge clk);
    check_eq("bp_ready1_grant", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_rsp();
    check_eq("bp2_id", rsp_id, 1);
    check_eq("bp2_data", rsp_data, 4);
    step();

    // Reset while waiting on the ALSU.
    req0_valid = 1'b1; req0_a = 3'd2; req0_b = 3'd2; req0_op = 3'd3; req0_ctrl = 7'd0;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_rsp_data", rsp_data, 0);
    check_eq("mid_rst_rsp_id", rsp_id, 0);
    check_eq("mid_rst_opcode", alsu_opcode, 0);
    step();
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
      step();
    end
    check_eq("no_rsp_after_rst", seen, 0);

    // Both requesters continuously valid: strict alternation starting at req0.
    req0_valid = 1'b1; req0_a = 3'd1; req0_b = 3'd1; req0_op = 3'd2; req0_ctrl = 7'd0;
    req1_valid = 1'b1; req1_a = 3'd2; req1_b = 3'd3; req1_op = 3'd3; req1_ctrl = 7'd0;
    grants = 0; resps = 0; last_id = 1'b0;
    for (n = 0; n < 80 && resps < 4; n++) begin
      @(negedge clk);
      check_eq("rr_onehot", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) begin
        check_eq("rr_order", req1_ready, grants % 2);
        last_id = req1_ready;
        grants++;
      end
      if (rsp_valid) begin
        check_eq("rr_rsp_id", rsp_id, last_id);
        check_eq("rr_rsp_data", rsp_data, last_id ? 6 : 2);
        resps++;
      end
      step();
    end
    check_eq("rr_resps", resps, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
